// File: rtl/des_pkg.sv
// Shared definitions for the iterative DES round sequencer: FSM states,
// round count, mode encodings and the encrypt key-rotation schedule.
package des_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ROUND = 3'd2,
        ST_FINAL = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int ROUNDS = 16;
    localparam int CNT_W  = $clog2(ROUNDS);

    localparam logic DES_ENC = 1'b0;
    localparam logic DES_DEC = 1'b1;

    // Left-rotation amounts of C/D per encrypt round 0..15 (sum = 28).
    localparam logic [1:0] ENC_SHIFT [ROUNDS] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

endpackage

// File: rtl/des_shift_rom.sv
// Per-round C/D rotation amount and direction; zero outside round cycles.
module des_shift_rom
    import des_pkg::*;
(
    input  logic [3:0] round_idx,
    input  logic       mode,
    input  logic       round_en,
    output logic [1:0] key_shift,
    output logic       key_dir
);

    logic [1:0] dec_shift [ROUNDS];

    // Decrypt walks the schedule backwards: round 0 uses the unrotated
    // PC-1 state (already K16), round i undoes encrypt rotation 16-i.
    generate
        for (genvar gi = 0; gi < ROUNDS; gi++) begin : g_dec_tbl
            if (gi == 0) begin : g_first
                assign dec_shift[gi] = 2'd0;
            end else begin : g_rest
                assign dec_shift[gi] = ENC_SHIFT[ROUNDS - gi];
            end
        end
    endgenerate

    always_comb begin
        key_shift = 2'd0;
        key_dir   = 1'b0;
        if (round_en) begin
            if (mode == DES_DEC) begin
                key_shift = dec_shift[round_idx];
                key_dir   = 1'b1;
            end else begin
                key_shift = ENC_SHIFT[round_idx];
            end
        end
    end

endmodule

// File: rtl/des_round_ctrl.sv
// Round sequencer for the iterative DES datapath: LOAD, 16 rounds, FINAL, DONE.
// All outputs decode registered state only.
module des_round_ctrl
    import des_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       decrypt,
    input  logic       abort,
    output logic       busy,
    output logic       load,
    output logic       round_en,
    output logic [3:0] round_idx,
    output logic [1:0] key_shift,
    output logic       key_dir,
    output logic       last_round,
    output logic       fp_en,
    output logic       done
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROUNDS - 1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             mode_reg, mode_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            mode_reg  <= DES_ENC;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            mode_reg  <= mode_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        mode_next  = mode_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_next = ST_LOAD;
                    mode_next  = decrypt;
                end
            end
            ST_LOAD: begin
                state_next = ST_ROUND;
                cnt_next   = '0;
            end
            ST_ROUND: begin
                if (cnt_reg == CNT_LAST) begin
                    state_next = ST_FINAL;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_FINAL: state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
        // Abort overrides everything once an operation is in flight.
        if (abort && state_reg != ST_IDLE) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
        end
    end

    assign busy       = (state_reg != ST_IDLE);
    assign load       = (state_reg == ST_LOAD);
    assign round_en   = (state_reg == ST_ROUND);
    assign round_idx  = round_en ? 4'(cnt_reg) : 4'd0;
    assign last_round = round_en && (cnt_reg == CNT_LAST);
    assign fp_en      = (state_reg == ST_FINAL);
    assign done       = (state_reg == ST_DONE);

    des_shift_rom u_shift_rom (
        .round_idx (round_idx),
        .mode      (mode_reg),
        .round_en  (round_en),
        .key_shift (key_shift),
        .key_dir   (key_dir)
    );

endmodule

// File: tb/tb_des_round_ctrl.sv
// Scoreboard bench for des_round_ctrl: stimulus queues the expected per-cycle
// output vector, a negedge monitor compares every cycle (idle when nothing queued).
module tb_des_round_ctrl;

    logic       clk = 1'b0;
    logic       rst, start, decrypt, abort;
    logic       busy, load, round_en, key_dir, last_round, fp_en, done;
    logic [3:0] round_idx;
    logic [1:0] key_shift;

    always #5 clk = ~clk;

    des_round_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .decrypt    (decrypt),
        .abort      (abort),
        .busy       (busy),
        .load       (load),
        .round_en   (round_en),
        .round_idx  (round_idx),
        .key_shift  (key_shift),
        .key_dir    (key_dir),
        .last_round (last_round),
        .fp_en      (fp_en),
        .done       (done)
    );

    typedef struct packed {
        int         cyc;
        logic       busy;
        logic       load;
        logic       round_en;
        logic [3:0] idx;
        logic [1:0] shift;
        logic       dir;
        logic       last;
        logic       fp;
        logic       done;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic mon_en = 1'b0;

    int enc_tbl [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    int dec_tbl [16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    always @(posedge clk) cyc <= cyc + 1;

    // Expected outputs for steps 0..upto of an operation whose LOAD is at base.
    task automatic push_op(input int base, input logic dec, input int upto);
        exp_t e;
        for (int k = 0; k <= upto; k++) begin
            e          = '0;
            e.cyc      = base + k;
            e.busy     = 1'b1;
            e.load     = (k == 0);
            e.round_en = (k >= 1 && k <= 16);
            e.idx      = e.round_en ? 4'(k - 1) : 4'd0;
            e.shift    = e.round_en ? 2'(dec ? dec_tbl[k-1] : enc_tbl[k-1]) : 2'd0;
            e.dir      = e.round_en && dec;
            e.last     = (k == 16);
            e.fp       = (k == 17);
            e.done     = (k == 18);
            exp_q.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        exp_t       e;
        logic [13:0] got, want;
        if (mon_en) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL stale_expect cyc=%0d: expected entry for cycle %0d never matched", cyc, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            e     = '0;
            e.cyc = cyc;
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc)
                e = exp_q.pop_front();
            got  = {busy, load, round_en, round_idx, key_shift, key_dir, last_round, fp_en, done};
            want = {e.busy, e.load, e.round_en, e.idx, e.shift, e.dir, e.last, e.fp, e.done};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL outputs cyc=%0d: got %b required %b (busy,load,ren,idx,shift,dir,last,fp,done)",
                         cyc, got, want);
            end
            if (done === 1'b1)
                $display("transaction done at cycle %0d dir=%0d", cyc, dut.mode_reg);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) step();
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 300 && exp_q.size() > 0; i++) step();
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d expected cycles still pending, required 0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) step();
    endtask

    int load_cyc;

    initial begin
        rst = 1'b1; start = 1'b0; decrypt = 1'b0; abort = 1'b0;
        step();
        mon_en = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        step();

        // Encrypt
        start = 1'b1; decrypt = 1'b0;
        push_op(cyc + 1, 1'b0, 18);
        step();
        start = 1'b0;
        wait_drain();

        // Decrypt, mode input flipped mid-run
        start = 1'b1; decrypt = 1'b1;
        push_op(cyc + 1, 1'b1, 18);
        step();
        start = 1'b0;
        repeat (6) step();
        decrypt = 1'b0;
        wait_drain();

        // start held for 60 cycles: exactly three operations, 20 cycles apart
        start = 1'b1; decrypt = 1'b0;
        push_op(cyc + 1, 1'b0, 18);
        push_op(cyc + 21, 1'b0, 18);
        push_op(cyc + 41, 1'b0, 18);
        repeat (60) step();
        start = 1'b0;
        wait_drain();

        // Abort at round 7, then restart one cycle later
        start = 1'b1;
        load_cyc = cyc + 1;
        push_op(load_cyc, 1'b0, 8);
        step();
        start = 1'b0;
        wait_until(load_cyc + 8);
        abort = 1'b1;
        step();
        abort = 1'b0; start = 1'b1;
        push_op(load_cyc + 10, 1'b0, 18);
        step();
        start = 1'b0;
        wait_drain();

        // Reset at round 3 with start high, then a clean decrypt... encrypt run
        start = 1'b1; decrypt = 1'b1;
        load_cyc = cyc + 1;
        push_op(load_cyc, 1'b1, 4);
        step();
        start = 1'b0;
        wait_until(load_cyc + 4);
        rst = 1'b1; start = 1'b1;
        step();
        rst = 1'b0; start = 1'b0;
        step();
        start = 1'b1; decrypt = 1'b0;
        push_op(load_cyc + 7, 1'b0, 18);
        step();
        start = 1'b0;
        wait_drain();

        // abort in IDLE blocks start: monitor expects idle throughout
        start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        repeat (5) step();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_empty: %0d entries left, required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
